// File: rtl/window_generator.sv
// rtl/window_generator.sv - 5x5 sliding window generator over a row-major pixel stream.
module window_generator #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_pixel,
  output logic signed [DATA_W-1:0] window [0:4][0:4],
  output logic                     out_valid,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  logic signed [DATA_W-1:0] win_q [0:4][0:4];
  logic signed [DATA_W-1:0] win_d [0:4][0:4];
  logic signed [DATA_W-1:0] line_q [0:3][0:IMG_W-1];

  // A start pulse makes this cycle's pixel (if any) land at (0,0).
  always_comb begin
    col_cur      = start ? '0 : col_q;
    row_cur      = start ? '0 : row_q;
    col_d        = col_cur;
    row_d        = row_cur;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_d        = win_q;
    if (in_valid) begin
      out_valid_d  = (row_cur >= RW'(4)) && (col_cur >= CW'(4));
      frame_done_d = (row_cur == RW'(IMG_H-1)) && (col_cur == CW'(IMG_W-1));
      if (col_cur == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (row_cur == RW'(IMG_H-1)) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
      end
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
      end
      win_d[0][4] = line_q[3][col_cur];
      win_d[1][4] = line_q[2][col_cur];
      win_d[2][4] = line_q[1][col_cur];
      win_d[3][4] = line_q[0][col_cur];
      win_d[4][4] = in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // line0 holds the row just above the incoming pixel, line3 the oldest row.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line_q[0][col_cur] <= in_pixel;
      line_q[1][col_cur] <= line_q[0][col_cur];
      line_q[2][col_cur] <= line_q[1][col_cur];
      line_q[3][col_cur] <= line_q[2][col_cur];
    end
  end

  assign window     = win_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_generator.sv
// tb/tb_window_generator.sv - directed bench for window_generator at 8x6.
module tb_window_generator;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] in_pixel = '0;
  logic signed [DW-1:0] window [0:4][0:4];
  logic                 out_valid;
  logic                 frame_done;

  int n_vec = 0;
  int n_bad = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  bit drv_qual = 1'b0;
  bit drv_done = 1'b0;
  int drv_r = 0;
  int drv_c = 0;
  int drv_mode = 0;

  window_generator #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .window(window), .out_valid(out_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int expv(input int m, input int r, input int c);
    return (m == 1) ? 32'h400 : 16 * r + c;
  endfunction

  // Checks every cycle's outputs against what the pixel accepted at that edge implies.
  always @(posedge clk) begin
    bit q, d;
    int r, c, m, mism;
    int sum;
    q = drv_qual && in_valid && !rst;
    d = drv_done && in_valid && !rst;
    r = drv_r;
    c = drv_c;
    m = drv_mode;
    #2;
    check_vec("out_valid", out_valid, q);
    check_vec("frame_done", frame_done, d);
    if (out_valid === 1'b1) win_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (q) begin
      mism = 0;
      sum = 0;
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          if (window[i][j] !== DW'(expv(m, r - 4 + i, c - 4 + j))) mism++;
          sum += int'(window[i][j]) * 32'h800;
        end
      end
      check_vec("win00", window[0][0], expv(m, r - 4, c - 4));
      check_vec("win44", window[4][4], expv(m, r, c));
      check_vec("win_elem_mismatches", mism, 0);
      if (m == 1) check_vec("conv_sum", sum >>> 10, 25 * 32'h800);
    end
  end

  task automatic idle();
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; drv_qual = 1'b0; drv_done = 1'b0;
  endtask

  task automatic pixel(input int m, input int r, input int c, input bit s);
    @(negedge clk);
    start = s; in_valid = 1'b1; in_pixel = DW'(expv(m, r, c));
    drv_qual = (r >= 4 && c >= 4); drv_done = (r == H - 1 && c == W - 1);
    drv_r = r; drv_c = c; drv_mode = m;
  endtask

  task automatic frame(input int m, input int idle_pct, input bit s, input int npix);
    for (int k = 0; k < npix; k++) begin
      if (idle_pct > 0 && int'($urandom_range(0, 99)) < idle_pct) idle();
      pixel(m, k / W, k % W, s && (k == 0));
    end
  endtask

  task automatic counts(input string tag, input int wins, input int dones);
    repeat (3) idle();
    check_vec({tag, "_windows"}, win_cnt, wins);
    check_vec({tag, "_frame_done"}, done_cnt, dones);
    win_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    #3;
    check_vec("rst_out_valid", out_valid, 0);
    check_vec("rst_frame_done", frame_done, 0);
    check_vec("rst_win00", window[0][0], 0);
    check_vec("rst_win44", window[4][4], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    win_cnt = 0;
    done_cnt = 0;

    frame(0, 0, 1'b0, W * H);
    counts("continuous", 8, 1);

    @(negedge clk);
    start = 1'b1;
    idle();
    frame(0, 50, 1'b0, W * H);
    counts("gapped", 8, 1);

    frame(1, 0, 1'b0, W * H);
    counts("unity", 8, 1);

    frame(1, 0, 1'b0, 20);
    frame(0, 0, 1'b1, W * H);
    counts("restart", 8, 1);

    frame(0, 0, 1'b0, 4 * W + 6);
    @(negedge clk);
    check_vec("pre_rst_out_valid", out_valid, 1);
    in_valid = 1'b0; drv_qual = 1'b0; drv_done = 1'b0; rst = 1'b1;
    #1;
    check_vec("async_rst_out_valid", out_valid, 0);
    check_vec("async_rst_win44", window[4][4], 0);
    check_vec("async_rst_win00", window[0][0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_vec("aborted_windows", win_cnt, 2);
    check_vec("aborted_frame_done", done_cnt, 0);
    win_cnt = 0;
    done_cnt = 0;
    frame(0, 0, 1'b0, W * H);
    counts("after_rst", 8, 1);

    frame(0, 0, 1'b0, W * H);
    frame(0, 0, 1'b0, W * H);
    counts("back_to_back", 16, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/window_generator.md
WINDOW_GENERATOR -- requirements
Module: window_generator

Interface
REQ-001 Parameter: DATA_W, default 16, pixel width in bits (signed fixed-point, 10 fractional bits, 0x0400 = 1.0).
REQ-002 Parameter: IMG_W, default 32, image width in pixels (>= 5).
REQ-003 Parameter: IMG_H, default 32, image height in pixels (>= 5).
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  synchronous one-cycle pulse that begins a new frame.
REQ-007 Port: in_valid  input  1  in_pixel is valid this cycle.
REQ-008 Port: in_pixel  input  DATA_W signed  pixel in row-major order.
REQ-009 Port: window  output  DATA_W signed x [0:4][0:4]  registered 5x5 window, [row][col], fed directly to the 5x5 convolution stage.
REQ-010 Port: out_valid  output  1  window holds a complete, valid window this cycle.
REQ-011 Port: frame_done  output  1  one-cycle pulse coincident with the last window of a frame.

Function
REQ-012 The block SHALL accept one pixel on every cycle with in_valid=1; there is no backpressure, and cycles with in_valid=0 SHALL change no state except clearing out_valid and frame_done.
REQ-013 The block SHALL track the position (r,c) of the next pixel with a column counter 0..IMG_W-1 and a row counter 0..IMG_H-1; c wraps to 0 and r increments after c=IMG_W-1.
REQ-014 The block SHALL hold the four previous image rows in four IMG_W-deep line buffers, indexed by c, read and written in the same accept cycle (read-before-write).
REQ-015 The block SHALL hold a 5x5 shift array; on each accept, columns shift left by one and column 4 loads {line3[c], line2[c], line1[c], line0[c], in_pixel} as rows 0..4.
REQ-016 When pixel (r,c) is accepted with r>=4 and c>=4, the block SHALL, on the next cycle, present window[i][j] = p(r-4+i, c-4+j) for i,j in 0..4, with out_valid=1.
REQ-017 Latency: exactly 1 cycle from the accepting edge to out_valid=1; out_valid is a single-cycle pulse per qualifying pixel.
REQ-018 Windows SHALL never span a row boundary; accepts with r<4 or c<4 SHALL leave out_valid=0.
REQ-019 Each frame SHALL yield exactly (IMG_H-4)*(IMG_W-4) windows.
REQ-020 frame_done SHALL be 1 in the same cycle as the window for pixel (IMG_H-1, IMG_W-1); both counters then wrap to 0, and the next pixel is (0,0) of a new frame.
REQ-021 start=1 SHALL zero both counters and clear out_valid/frame_done on the next edge; line buffer contents are don't-care.
REQ-022 If start and in_valid are both 1, the pixel SHALL be accepted as pixel (0,0) of the new frame.
REQ-023 window contents when out_valid=0 are unspecified; the pixel data path SHALL perform no arithmetic, so pixel values pass bit-exact.

Reset
REQ-024 While rst=1, counters, out_valid and frame_done SHALL be 0 immediately (asynchronously), and window SHALL be 0.
REQ-025 Line buffers need no reset; after rst deasserts, the next accepted pixel is (0,0).
REQ-026 rst asserted mid-frame SHALL abort the frame without emitting frame_done.

Verification (IMG_W=8, IMG_H=6, p(r,c)=16*r+c)
REQ-027 Stream a full frame with continuous in_valid -> first out_valid one cycle after accepting (4,4) with window[0][0]=0x0000 and window[4][4]=0x0044; 8 windows in total; frame_done only on the window with window[4][4]=0x0057.
REQ-028 Same frame with in_valid randomly deasserted 50% of the time -> identical sequence of 8 windows; out_valid never asserted on an idle-following cycle.
REQ-029 All pixels 0x0400 -> every window element 0x0400, so the downstream convolution with a filter of all 0x0800 gives 25*2.0.
REQ-030 Pulse start after 20 pixels, then send a full frame -> exactly 8 windows, none containing pre-start data.
REQ-031 Assert rst at pixel (4,6), release it, then send a full frame -> out_valid=0 and window=0 during reset, no frame_done for the aborted frame, and 8 correct windows afterwards.
REQ-032 Two back-to-back frames with no gap -> 16 windows and two frame_done pulses; the first window of frame 2 equals the first window of frame 1.
